// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory stage.
// Funct3 size codes, sequencer states, byte-enable and load-extension helpers.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic size_ok(logic [2:0] code, logic is_store);
        logic ok;
        case (code)
            SZ_B, SZ_H, SZ_W: ok = 1'b1;
            SZ_BU, SZ_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(logic [2:0] code, logic [1:0] off);
        logic [3:0] be;
        case (code)
            SZ_B, SZ_BU: be = 4'b0001 << off;
            SZ_H, SZ_HU: be = 4'b0011 << off;
            SZ_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_ext(logic [2:0] code, logic [1:0] off,
                                             logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (code)
            SZ_B:    res = {{24{sh[7]}}, sh[7:0]};
            SZ_BU:   res = {24'h0, sh[7:0]};
            SZ_H:    res = {{16{sh[15]}}, sh[15:0]};
            SZ_HU:   res = {16'h0, sh[15:0]};
            SZ_W:    res = sh;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between execute and the data-memory stage.
// master drives req_i/memRW/dataSec_i/dataW_i/addr_i; slave drives the rest.
interface dmem_if;
    logic        req_i;
    logic        memRW;
    logic [2:0]  dataSec_i;
    logic [31:0] dataW_i;
    logic [31:0] addr_i;
    logic [31:0] data_o;
    logic [31:0] alu_o;
    logic        valid_o;
    logic        err_o;
    logic        ready_o;

    modport master (
        output req_i, memRW, dataSec_i, dataW_i, addr_i,
        input  data_o, alu_o, valid_o, err_o, ready_o
    );

    modport slave (
        input  req_i, memRW, dataSec_i, dataW_i, addr_i,
        output data_o, alu_o, valid_o, err_o, ready_o
    );
endinterface

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH_WORDS x 32 storage, byte-enable sync write, sync read.
// Ports: clk, we/be/waddr/wdata (write), re/raddr/rdata (registered read).
module dmem_sram #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dmem_stage.sv
// dmem_stage: data-memory pipeline stage (B/H/W loads and stores), clears
// memory after reset. Ports: clk, rst, bus (dmem_if.slave). Macro: DMEM_MISALIGN_EXC_EN.
module dmem_stage #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] INIT_VAL    = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    import dmem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e      state;
    logic [IDX_W-1:0] cnt;
    logic             ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN:     ready_q <= 1'b1;
                default: state   <= INIT;
            endcase
        end
    end

    logic [2:0]       sec;
    logic             acc;
    logic             oor;
    logic             rsv;
    logic             mis;
    logic             fault;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [31:0]      st_data;

    assign sec   = bus.dataSec_i;
    // A request arriving alongside rst is discarded with everything else.
    assign acc   = bus.req_i & ready_q & ~rst;
    assign oor   = (bus.addr_i >> (IDX_W + 2)) != 32'h0;
    assign rsv   = ~size_ok(sec, bus.memRW);
    assign fault = oor | rsv | mis;
    assign idx   = bus.addr_i[IDX_W+1:2];

    always_comb begin
        mis = 1'b0;
        off = bus.addr_i[1:0];
`ifdef DMEM_MISALIGN_EXC_EN
        if (sec == SZ_H || sec == SZ_HU) mis = bus.addr_i[0];
        if (sec == SZ_W)                 mis = |bus.addr_i[1:0];
`else
        // Drop the low bits so a misaligned access stays inside its word.
        if (sec == SZ_H || sec == SZ_HU) off = {bus.addr_i[1], 1'b0};
        if (sec == SZ_W)                 off = 2'b00;
`endif
    end

    always_comb begin
        st_data = bus.dataW_i;
        case (sec)
            SZ_B:    st_data = {4{bus.dataW_i[7:0]}};
            SZ_H:    st_data = {2{bus.dataW_i[15:0]}};
            default: st_data = bus.dataW_i;
        endcase
    end

    logic             init_we;
    logic             st_we;
    logic             ram_we;
    logic [3:0]       ram_be;
    logic [IDX_W-1:0] ram_waddr;
    logic [31:0]      ram_wdata;
    logic             ram_re;
    logic [31:0]      ram_rdata;

    assign init_we   = (state == INIT) & ~rst;
    assign st_we     = acc & bus.memRW & ~fault;
    assign ram_we    = init_we | st_we;
    assign ram_be    = init_we ? 4'hF     : byte_en(sec, off);
    assign ram_waddr = init_we ? cnt      : idx;
    assign ram_wdata = init_we ? INIT_VAL : st_data;
    assign ram_re    = acc & ~bus.memRW & ~fault;

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    logic        valid_q;
    logic        err_q;
    logic        ld_q;
    logic [31:0] alu_q;
    logic [2:0]  sec_q;
    logic [1:0]  off_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
            alu_q   <= 32'h0;
            sec_q   <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            valid_q <= acc;
            err_q   <= acc & fault;
            if (acc) begin
                alu_q <= bus.addr_i;
                ld_q  <= ~bus.memRW & ~fault;
                sec_q <= sec;
                off_q <= off;
            end
        end
    end

    // Stores and faulted accesses present zero; only good loads show data.
    assign bus.data_o  = (valid_q & ld_q) ? load_ext(sec_q, off_q, ram_rdata)
                                          : 32'h0;
    assign bus.alu_o   = alu_q;
    assign bus.valid_o = valid_q;
    assign bus.err_o   = err_q;
    assign bus.ready_o = ready_q;

endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: scoreboard bench for dmem_stage with DEPTH_WORDS=16.
// Directed stimulus pushes expectations; a negedge monitor pops and compares.
module tb_dmem_stage;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_if bus();

    dmem_stage #(
        .DEPTH_WORDS (DEPTH),
        .INIT_VAL    (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] alu;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 alu_o=%h, expected no response",
                         bus.alu_o);
            end else begin
                e = q.pop_front();
                check("data_o", bus.data_o, e.data);
                check("err_o", {31'h0, bus.err_o}, {31'h0, e.err});
                check("alu_o", bus.alu_o, e.alu);
                check("latency", cyc, e.cyc + 1);
            end
        end else if (bus.err_o === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL err_without_valid: got err_o=1, expected 0");
        end
    end

    task automatic issue(input logic rw, input logic [2:0] sec,
                         input logic [31:0] wd, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
        bus.req_i     = 1'b1;
        bus.memRW     = rw;
        bus.dataSec_i = sec;
        bus.dataW_i   = wd;
        bus.addr_i    = a;
        q.push_back('{data: exp_d, alu: a, err: exp_e, cyc: cyc});
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_n,
                              input int req_until);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ready_o !== 1'b1 && n < 100) begin
            n++;
            if (n >= req_until) bus.req_i = 1'b0;
            @(negedge clk);
        end
        bus.req_i = 1'b0;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got ready_o=0 after %0d cycles, expected 1", name, n);
        end
        check(name, n, exp_n);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        check(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_i     = 1'b0;
        bus.memRW     = 1'b0;
        bus.dataSec_i = 3'b010;
        bus.dataW_i   = 32'h0;
        bus.addr_i    = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_o", bus.data_o, 32'h0);
        check("rst_alu_o", bus.alu_o, 32'h0);
        check("rst_valid_o", {31'h0, bus.valid_o}, 32'h0);
        check("rst_err_o", {31'h0, bus.err_o}, 32'h0);
        check("rst_ready_o", {31'h0, bus.ready_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready("clear_len", DEPTH, 0);

        // Every word cleared
        for (int i = 0; i < DEPTH; i++)
            issue(1'b0, 3'b010, 32'h0, 32'(i * 4), 32'h0, 1'b0);

        // Store word, then sub-word loads with extension
        issue(1'b1, 3'b010, 32'h8899AABB, 32'h4, 32'h0, 1'b0);
        issue(1'b0, 3'b000, 32'h0, 32'h4, 32'hFFFFFFBB, 1'b0);
        issue(1'b0, 3'b100, 32'h0, 32'h7, 32'h00000088, 1'b0);
        issue(1'b0, 3'b001, 32'h0, 32'h6, 32'hFFFF8899, 1'b0);
        issue(1'b0, 3'b101, 32'h0, 32'h4, 32'h0000AABB, 1'b0);

        // Byte and half stores into lanes
        issue(1'b1, 3'b000, 32'h00000055, 32'h9, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0, 32'h8, 32'h00005500, 1'b0);
        issue(1'b1, 3'b001, 32'h00001234, 32'hA, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0, 32'h8, 32'h12345500, 1'b0);

        // Out of range
        issue(1'b1, 3'b010, 32'hDEADBEEF, 32'h40, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h0, 32'h40, 32'h0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = (i == 1) ? 32'h8899AABB : (i == 2) ? 32'h12345500 : 32'h0;
            issue(1'b0, 3'b010, 32'h0, 32'(i * 4), w, 1'b0);
        end

        // Last word boundary
        issue(1'b1, 3'b010, 32'hCAFEF00D, 32'h3C, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0, 32'h3C, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 3'b000, 32'h0, 32'h3F, 32'hFFFFFFCA, 1'b0);
        issue(1'b0, 3'b101, 32'h0, 32'h3E, 32'h0000CAFE, 1'b0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_EXC_EN
        issue(1'b0, 3'b010, 32'h0, 32'h6, 32'h0, 1'b1);
        issue(1'b1, 3'b001, 32'h00007777, 32'h3D, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h0, 32'h3C, 32'hCAFEF00D, 1'b0);
`else
        issue(1'b0, 3'b010, 32'h0, 32'h6, 32'h8899AABB, 1'b0);
        issue(1'b1, 3'b001, 32'h00007777, 32'h3D, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h0, 32'h3C, 32'hCAFE7777, 1'b0);
`endif

        // Reserved codes
        issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h000000FF, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'b111, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);
        drain("drain_run");

        // Reset mid-clear with requests held during INIT
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_i     = 1'b1;
        bus.memRW     = 1'b1;
        bus.dataSec_i = 3'b010;
        bus.dataW_i   = 32'h11111111;
        bus.addr_i    = 32'h4;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready("restart_len", DEPTH, 10);
        for (int i = 0; i < DEPTH; i++)
            issue(1'b0, 3'b010, 32'h0, 32'(i * 4), 32'h0, 1'b0);
        drain("drain_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
